ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 23 ++
 rtl/ex_stage_slot.sv | 33 +++
 rtl/ex_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: ALU opcode encoding and default datapath width.
// The ALU and the decoder import the same package, so the encoding lives in one place.
package ex_stage_pkg;

  localparam int EX_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  // Carry and overflow only mean something for the arithmetic ops.
  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ex_stage_slot.sv
// Single-entry valid/ready holding register; data and valid clear on reset.
// Accepts when empty or when the current entry leaves on the same edge.
module pipe_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  logic load;

  assign enq_ready = ~deq_valid | deq_ready;
  assign load      = enq_valid & enq_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_valid <= 1'b0;
      deq_data  <= '0;
    end else if (load) begin
      deq_valid <= 1'b1;
      deq_data  <= enq_data;
    end else if (deq_ready) begin
      deq_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Two-slot execute stage: S1 holds the issued op and drives the external ALU,
// S2 holds the captured result for the downstream handshake.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = EX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_fwd_a,
  input  logic                  in_fwd_b,
  input  logic [4:0]            in_rd,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_zero,
  output logic                  out_overflow,
  output logic                  out_carry
);

  localparam int S1_W = 2 * DATA_WIDTH + 10;
  localparam int S2_W = DATA_WIDTH + 8;

  logic [S1_W-1:0]       s1_d, s1_q;
  logic                  s1_valid;
  logic [2:0]            s1_op;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic                  s1_fwd_a, s1_fwd_b;
  logic [4:0]            s1_rd;

  logic [S2_W-1:0]       s2_d, s2_q;
  logic                  s2_ready, s2_load, arith;
  logic [DATA_WIDTH-1:0] last_result;

  // Immediate selection happens at capture; forwarding is resolved later from last_result.
  assign s1_d = {in_op, in_a, (in_use_imm ? in_imm : in_b), in_fwd_a, in_fwd_b, in_rd};
  assign {s1_op, s1_a, s1_b, s1_fwd_a, s1_fwd_b, s1_rd} = s1_q;

  pipe_slot #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_valid (in_valid),
    .enq_ready (in_ready),
    .enq_data  (s1_d),
    .deq_valid (s1_valid),
    .deq_ready (s2_ready),
    .deq_data  (s1_q)
  );

  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = 3'b000;
    if (s1_valid) begin
      alu_A     = s1_fwd_a ? last_result : s1_a;
      alu_B     = s1_fwd_b ? last_result : s1_b;
      alu_ALUop = s1_op;
    end
  end

  assign arith   = is_addsub(s1_op);
  assign s2_load = s1_valid & s2_ready;
  assign s2_d    = {alu_Result, alu_Zero, arith & alu_CarryOut, arith & alu_Overflow, s1_rd};

  pipe_slot #(.WIDTH(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_valid (s1_valid),
    .enq_ready (s2_ready),
    .enq_data  (s2_d),
    .deq_valid (out_valid),
    .deq_ready (out_ready),
    .deq_data  (s2_q)
  );

  assign {out_result, out_zero, out_carry, out_overflow, out_rd} = s2_q;

  // Survives S2 draining so a later forwarded op still sees the newest result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_result <= '0;
    end else if (s2_load) begin
      last_result <= alu_Result;
    end
  end

endmodule
